// File: rtl/cs_loader_pkg.sv
// Shared control-store loader definitions: state encoding and store geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cs_loader_pkg;

  localparam int CS_ADDR_W = 13;
  localparam int CS_WORDS  = 8192;
  localparam int CS_DATA_W = 64;

  // Loader sequence for one microword: fetch, settle, strobe, release.
  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_SETUP = 3'd1,
    S_WRITE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } ld_state_t;

endpackage

// File: rtl/cs_addr_counter.sv
// Control-store address (LUA) counter with clear, increment and last-address flag.
// Latency: address updates one cycle after clr/inc; at_last is combinational from the register.
// Backpressure: none; the loader FSM decides when to step.
module cs_addr_counter import cs_loader_pkg::*; #(
  parameter int ADDR_W    = CS_ADDR_W,
  parameter int LAST_ADDR = CS_WORDS - 1
) (
  input  logic              clk,
  input  logic              mr_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              at_last
);

  // Address register: master reset and reload both restart the load at word 0.
  always_ff @(posedge clk) begin
    if (!mr_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc) begin
      addr <= addr + 1'b1;
    end
  end

  // The FSM stops before incrementing past this, so the counter never wraps.
  assign at_last = (addr == ADDR_W'(LAST_ADDR));

endmodule

// File: rtl/cs_loader.sv
// Writable control-store loader: pulls microwords from the boot source and writes them at LUA 0..LAST_ADDR.
// Latency: 4 cycles per word minimum (REQ, SETUP, WRITE, HOLD); all outputs registered.
// Backpressure: waits in REQ while SRC_RDY is low; each word consumed is acknowledged by a one-cycle SRC_ACK.
module cs_loader import cs_loader_pkg::*; #(
  parameter int ADDR_W    = CS_ADDR_W,
  parameter int DATA_W    = CS_DATA_W,
  parameter int LAST_ADDR = CS_WORDS - 1
) (
  input  logic              CLK,
  input  logic              MR_n,
  input  logic              START,
  input  logic              SRC_RDY,
  input  logic [DATA_W-1:0] SRC_DATA,
  output logic              SRC_ACK,
  output logic [ADDR_W-1:0] CS_ADDR,
  output logic              LUA12,
  output logic [DATA_W-1:0] CS_DATA,
  output logic              CS_WE_n,
  output logic              LCS_n,
  output logic              DONE
);

  ld_state_t state;
  logic      at_last;
  logic      addr_clr;
  logic      addr_inc;

  // Step to the next word only from HOLD; restart at 0 when a reload is accepted.
  assign addr_inc = (state == S_HOLD) && !at_last;
  assign addr_clr = (state == S_DONE) && START;

  cs_addr_counter #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (LAST_ADDR)
  ) u_addr (
    .clk     (CLK),
    .mr_n    (MR_n),
    .clr     (addr_clr),
    .inc     (addr_inc),
    .addr    (CS_ADDR),
    .at_last (at_last)
  );

  // Upper/lower control-store half select follows the address register directly.
  assign LUA12 = CS_ADDR[ADDR_W-1];

  // Load sequencer with registered strobes; SRC_ACK and CS_WE_n default inactive so both are single-cycle pulses.
  always_ff @(posedge CLK) begin
    if (!MR_n) begin
      state   <= S_REQ;
      CS_DATA <= '0;
      CS_WE_n <= 1'b1;
      SRC_ACK <= 1'b0;
      LCS_n   <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      SRC_ACK <= 1'b0;
      CS_WE_n <= 1'b1;
      case (state)
        S_REQ: begin
          if (SRC_RDY) begin
            CS_DATA <= SRC_DATA;
            SRC_ACK <= 1'b1;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          // Address and data settled for a full cycle; strobe next.
          CS_WE_n <= 1'b0;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (at_last) begin
            LCS_n <= 1'b1;
            DONE  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_REQ;
          end
        end
        S_DONE: begin
          if (START) begin
            LCS_n <= 1'b0;
            DONE  <= 1'b0;
            state <= S_REQ;
          end
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule
